// File: rtl/bullet_pkg.sv
// Shared types and default parameters for the bullet fire scheduler.
package bullet_pkg;

    // Launch FSM: IDLE accepts a shot, COOLDOWN locks out further shots.
    typedef enum logic {
        IDLE     = 1'b0,
        COOLDOWN = 1'b1
    } fire_state_t;

    localparam int COORD_W       = 10;
    localparam int DEF_NUM_SLOTS = 4;
    localparam int DEF_COOLDOWN  = 8;
    localparam int DEF_LIFETIME  = 255;
    localparam int DEF_SCREEN_W  = 640;
    localparam int DEF_SCREEN_H  = 480;

    // Counter width helper: never narrower than one bit.
    function automatic int bits_for(input int max_val);
        return (max_val <= 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/bullet_slot.sv
// One bullet slot: position, velocity and remaining life, plus the
// retire decision (hit, out of lifetime, or leaving the playfield).
module bullet_slot
    import bullet_pkg::*;
#(
    parameter int LIFETIME = DEF_LIFETIME,
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H
) (
    input  logic               clk2,
    input  logic               Reset,
    input  logic               i_load,
    input  logic               i_hit,
    input  logic [COORD_W-1:0] i_x,
    input  logic [COORD_W-1:0] i_y,
    input  logic [COORD_W-1:0] i_dx,
    input  logic [COORD_W-1:0] i_dy,
    output logic               o_active,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y
);

    localparam int                 LW        = bits_for(LIFETIME);
    localparam logic [LW-1:0]      LIFE_INIT = LW'(LIFETIME);
    localparam logic [COORD_W:0]   X_LIM     = (COORD_W + 1)'(SCREEN_W);
    localparam logic [COORD_W:0]   Y_LIM     = (COORD_W + 1)'(SCREEN_H);

    logic               r_active;
    logic [COORD_W-1:0] r_x, r_y, r_dx, r_dy;
    logic [LW-1:0]      r_life;

    logic [COORD_W-1:0] w_nx, w_ny;
    logic               w_retire;

    // Velocity is two's complement, so a plain 10-bit add wraps modulo 1024;
    // moving left past 0 lands at >= 1000, which the bounds test retires.
    assign w_nx     = r_x + r_dx;
    assign w_ny     = r_y + r_dy;
    assign w_retire = (r_life == '0) || ({1'b0, w_nx} >= X_LIM) || ({1'b0, w_ny} >= Y_LIM);

    // Slot state: hit beats retire beats move; load only touches a free slot,
    // so a hit on an inactive slot has no effect.
    always_ff @(posedge clk2) begin
        if (!Reset) begin
            r_active <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_dx     <= '0;
            r_dy     <= '0;
            r_life   <= '0;
        end else if (r_active) begin
            if (i_hit || w_retire) begin
                r_active <= 1'b0;
            end else begin
                r_x    <= w_nx;
                r_y    <= w_ny;
                r_life <= r_life - LW'(1);
            end
        end else if (i_load) begin
            r_active <= 1'b1;
            r_x      <= i_x;
            r_y      <= i_y;
            r_dx     <= i_dx;
            r_dy     <= i_dy;
            r_life   <= LIFE_INIT;
        end
    end

    assign o_active = r_active;
    assign o_x      = r_x;
    assign o_y      = r_y;

endmodule

// File: rtl/bullet_fire_scheduler.sv
// Fire-key scheduler: edge-detects the fire key, enforces a cooldown between
// shots, allocates the lowest free bullet slot and drives NUM_SLOTS slots.
module bullet_fire_scheduler #(
    parameter int NUM_SLOTS = bullet_pkg::DEF_NUM_SLOTS,
    parameter int COOLDOWN  = bullet_pkg::DEF_COOLDOWN,
    parameter int LIFETIME  = bullet_pkg::DEF_LIFETIME,
    parameter int SCREEN_W  = bullet_pkg::DEF_SCREEN_W,
    parameter int SCREEN_H  = bullet_pkg::DEF_SCREEN_H
) (
    input  logic                                    clk2,
    input  logic                                    Reset,
    input  logic                                    fire_req,
    input  logic [bullet_pkg::COORD_W-1:0]          turret_x,
    input  logic [bullet_pkg::COORD_W-1:0]          turret_y,
    input  logic [bullet_pkg::COORD_W-1:0]          turret_dx,
    input  logic [bullet_pkg::COORD_W-1:0]          turret_dy,
    input  logic [NUM_SLOTS-1:0]                    slot_hit,
    output logic [NUM_SLOTS-1:0]                    slot_active,
    output logic [bullet_pkg::COORD_W*NUM_SLOTS-1:0] slot_x,
    output logic [bullet_pkg::COORD_W*NUM_SLOTS-1:0] slot_y,
    output logic                                    fire_ack,
    output logic                                    fire_dropped,
    output logic                                    cooldown_busy
);
    import bullet_pkg::*;

    localparam int            CW       = bits_for(COOLDOWN - 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(COOLDOWN - 1);

    logic                 r_fire_q;
    logic                 w_fire_evt;
    fire_state_t          r_state, w_state_nxt;
    logic [CW-1:0]        r_cnt, w_cnt_nxt;
    logic                 w_launch, w_drop;
    logic                 r_ack, r_drop;
    logic                 w_any_free;
    logic [NUM_SLOTS-1:0] w_free_sel;
    logic [NUM_SLOTS-1:0] w_load;

    assign w_fire_evt = fire_req & ~r_fire_q;

    // Fire-key history; resets high so a key held through reset never fires.
    always_ff @(posedge clk2) begin
        if (!Reset) r_fire_q <= 1'b1;
        else        r_fire_q <= fire_req;
    end

    // Lowest-index free slot, judged on registered occupancy so a slot freed
    // this edge is only reusable from the next one.
    always_comb begin
        w_free_sel = '0;
        w_any_free = 1'b0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (!slot_active[k] && !w_any_free) begin
                w_free_sel[k] = 1'b1;
                w_any_free    = 1'b1;
            end
        end
    end

    assign w_load = w_launch ? w_free_sel : '0;

    // FSM next state: launch or drop from IDLE, count down in COOLDOWN
    // (fire events there are simply ignored).
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_launch    = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_fire_evt) begin
                    if (w_any_free) begin
                        w_launch    = 1'b1;
                        w_state_nxt = bullet_pkg::COOLDOWN;
                        w_cnt_nxt   = CNT_LOAD;
                    end else begin
                        w_drop = 1'b1;
                    end
                end
            end
            bullet_pkg::COOLDOWN: begin
                if (r_cnt == '0) w_state_nxt = IDLE;
                else             w_cnt_nxt   = r_cnt - CW'(1);
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM state register and the one-cycle ack/drop pulses.
    always_ff @(posedge clk2) begin
        if (!Reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ack   <= w_launch;
            r_drop  <= w_drop;
        end
    end

    assign fire_ack      = r_ack;
    assign fire_dropped  = r_drop;
    assign cooldown_busy = (r_state == bullet_pkg::COOLDOWN);

    for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
        bullet_slot #(
            .LIFETIME (LIFETIME),
            .SCREEN_W (SCREEN_W),
            .SCREEN_H (SCREEN_H)
        ) u_slot (
            .clk2     (clk2),
            .Reset    (Reset),
            .i_load   (w_load[k]),
            .i_hit    (slot_hit[k]),
            .i_x      (turret_x),
            .i_y      (turret_y),
            .i_dx     (turret_dx),
            .i_dy     (turret_dy),
            .o_active (slot_active[k]),
            .o_x      (slot_x[COORD_W*k +: COORD_W]),
            .o_y      (slot_y[COORD_W*k +: COORD_W])
        );
    end

endmodule

// File: tb/tb_bullet_fire_scheduler.sv
// Self-checking bench for bullet_fire_scheduler: directed scenarios plus a
// randomized run against a behavioural model of shots, cooldown and bullets.
module tb_bullet_fire_scheduler;

    localparam int NS = 4;
    localparam int CD = 8;
    localparam int LT = 255;
    localparam int SW = 640;
    localparam int SH = 480;

    logic            clk2 = 1'b0;
    logic            Reset = 1'b0;
    logic            fire_req = 1'b0;
    logic [9:0]      turret_x = '0, turret_y = '0, turret_dx = '0, turret_dy = '0;
    logic [NS-1:0]   slot_hit = '0;
    logic [NS-1:0]   slot_active;
    logic [10*NS-1:0] slot_x, slot_y;
    logic            fire_ack, fire_dropped, cooldown_busy;

    bullet_fire_scheduler #(
        .NUM_SLOTS (NS), .COOLDOWN (CD), .LIFETIME (LT), .SCREEN_W (SW), .SCREEN_H (SH)
    ) dut (
        .clk2          (clk2),
        .Reset         (Reset),
        .fire_req      (fire_req),
        .turret_x      (turret_x),
        .turret_y      (turret_y),
        .turret_dx     (turret_dx),
        .turret_dy     (turret_dy),
        .slot_hit      (slot_hit),
        .slot_active   (slot_active),
        .slot_x        (slot_x),
        .slot_y        (slot_y),
        .fire_ack      (fire_ack),
        .fire_dropped  (fire_dropped),
        .cooldown_busy (cooldown_busy)
    );

    always #5 clk2 = ~clk2;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: bullets as plain integer records, cooldown as
    // "edges since the last accepted shot".
    bit m_act  [NS];
    int m_x    [NS];
    int m_y    [NS];
    int m_dx   [NS];
    int m_dy   [NS];
    int m_life [NS];
    int m_edge = 0;
    int m_last = -1000;
    bit m_prev = 1'b1;
    bit m_ack  = 1'b0;
    bit m_drop = 1'b0;

    task automatic model_edge();
        bit evt, idle;
        int fr, nx, ny;
        m_edge++;
        if (!Reset) begin
            for (int k = 0; k < NS; k++) begin
                m_act[k] = 0; m_x[k] = 0; m_y[k] = 0; m_dx[k] = 0; m_dy[k] = 0; m_life[k] = 0;
            end
            m_prev = 1; m_last = -1000; m_ack = 0; m_drop = 0;
            return;
        end
        evt    = fire_req && !m_prev;
        m_prev = fire_req;
        idle   = (m_edge - m_last) > CD;
        fr     = -1;
        for (int k = 0; k < NS; k++) if (!m_act[k] && fr < 0) fr = k;
        m_ack = 0; m_drop = 0;
        for (int k = 0; k < NS; k++) begin
            if (m_act[k]) begin
                if (slot_hit[k]) m_act[k] = 0;
                else begin
                    nx = (m_x[k] + m_dx[k]) % 1024;
                    ny = (m_y[k] + m_dy[k]) % 1024;
                    if (m_life[k] == 0 || nx >= SW || ny >= SH) m_act[k] = 0;
                    else begin m_x[k] = nx; m_y[k] = ny; m_life[k]--; end
                end
            end
        end
        if (evt && idle) begin
            if (fr >= 0) begin
                m_act[fr] = 1; m_x[fr] = int'(turret_x); m_y[fr] = int'(turret_y);
                m_dx[fr] = int'(turret_dx); m_dy[fr] = int'(turret_dy); m_life[fr] = LT;
                m_ack = 1; m_last = m_edge;
            end else m_drop = 1;
        end
    endtask

    function automatic logic [NS-1:0] m_act_vec();
        logic [NS-1:0] v = '0;
        for (int k = 0; k < NS; k++) v[k] = m_act[k];
        return v;
    endfunction

    function automatic logic [10*NS-1:0] m_pos(input bit use_y);
        logic [10*NS-1:0] v = '0;
        for (int k = 0; k < NS; k++) if (m_act[k]) v[10*k +: 10] = 10'(use_y ? m_y[k] : m_x[k]);
        return v;
    endfunction

    function automatic logic [10*NS-1:0] act_mask();
        logic [10*NS-1:0] v = '0;
        for (int k = 0; k < NS; k++) if (m_act[k]) v[10*k +: 10] = 10'h3FF;
        return v;
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk2);
        #1;
    endtask

    task automatic do_reset();
        Reset = 0; fire_req = 0; slot_hit = '0;
        tick();
        Reset = 1;
        tick();
    endtask

    task automatic shoot(input int x, input int y, input int dx, input int dy);
        turret_x = 10'(x); turret_y = 10'(y); turret_dx = 10'(dx); turret_dy = 10'(dy);
        fire_req = 1; tick();
        fire_req = 0; repeat (10) tick();
    endtask

    task automatic test_reset();
        Reset = 0; fire_req = 1;
        tick(); tick();
        n_checks++; if (slot_active !== '0) $display("FAIL reset_active: got %b want 0", slot_active); else n_pass++;
        n_checks++; if (slot_x !== '0 || slot_y !== '0) $display("FAIL reset_pos: got x=%h y=%h want 0", slot_x, slot_y); else n_pass++;
        n_checks++; if ({fire_ack, fire_dropped, cooldown_busy} !== 3'b000)
            $display("FAIL reset_flags: got ack/drop/busy=%b want 000", {fire_ack, fire_dropped, cooldown_busy}); else n_pass++;
        Reset = 1;
        tick(); tick();
        n_checks++; if (fire_ack !== 1'b0 || slot_active !== '0)
            $display("FAIL held_through_reset: got ack=%b active=%b want 0/0", fire_ack, slot_active); else n_pass++;
        fire_req = 0; tick();
    endtask

    task automatic test_launch();
        turret_x = 10'd320; turret_y = 10'd240; turret_dx = 10'd2; turret_dy = 10'h3FF;
        fire_req = 1; tick();
        n_checks++; if (fire_ack !== 1'b1 || slot_active !== 4'b0001 || cooldown_busy !== 1'b1)
            $display("FAIL launch_ack: got ack=%b active=%b busy=%b want 1/0001/1", fire_ack, slot_active, cooldown_busy); else n_pass++;
        n_checks++; if (slot_x[9:0] !== 10'd320 || slot_y[9:0] !== 10'd240)
            $display("FAIL launch_pos: got (%0d,%0d) want (320,240)", slot_x[9:0], slot_y[9:0]); else n_pass++;
        fire_req = 0; tick();
        n_checks++; if (slot_x[9:0] !== 10'd322 || slot_y[9:0] !== 10'd239 || fire_ack !== 1'b0)
            $display("FAIL first_move: got (%0d,%0d) ack=%b want (322,239) 0", slot_x[9:0], slot_y[9:0], fire_ack); else n_pass++;
        repeat (10) tick();
    endtask

    task automatic test_hold_repeat();
        int acks = 0;
        do_reset();
        turret_x = 10'd100; turret_y = 10'd100; turret_dx = '0; turret_dy = '0;
        fire_req = 1;
        repeat (40) begin tick(); if (fire_ack) acks++; end
        n_checks++; if (acks != 1) $display("FAIL held_key_acks: got %0d want 1", acks); else n_pass++;
        do_reset();
        fire_req = 1; tick();
        n_checks++; if (fire_ack !== 1'b1) $display("FAIL cd_first_ack: got %b want 1", fire_ack); else n_pass++;
        fire_req = 0; tick(); tick();
        fire_req = 1; tick();
        n_checks++; if (fire_ack !== 1'b0 || fire_dropped !== 1'b0 || slot_active !== 4'b0001)
            $display("FAIL cd_ignored: got ack=%b drop=%b active=%b want 0/0/0001", fire_ack, fire_dropped, slot_active); else n_pass++;
        fire_req = 0; repeat (5) tick();
        fire_req = 1; tick();
        n_checks++; if (fire_ack !== 1'b1 || slot_active !== 4'b0011)
            $display("FAIL cd_expired_launch: got ack=%b active=%b want 1/0011", fire_ack, slot_active); else n_pass++;
        fire_req = 0; repeat (10) tick();
    endtask

    task automatic test_full_drop();
        do_reset();
        for (int k = 0; k < 4; k++) shoot(50 + 20 * k, 60, 0, 0);
        n_checks++; if (slot_active !== 4'b1111) $display("FAIL fill_slots: got %b want 1111", slot_active); else n_pass++;
        fire_req = 1; tick();
        n_checks++; if (fire_dropped !== 1'b1 || fire_ack !== 1'b0 || cooldown_busy !== 1'b0)
            $display("FAIL drop_pulse: got drop=%b ack=%b busy=%b want 1/0/0", fire_dropped, fire_ack, cooldown_busy); else n_pass++;
        n_checks++; if (slot_active !== 4'b1111 || slot_x !== {10'd110, 10'd90, 10'd70, 10'd50})
            $display("FAIL drop_no_change: got active=%b x=%h", slot_active, slot_x); else n_pass++;
        fire_req = 0; tick();
        n_checks++; if (fire_dropped !== 1'b0) $display("FAIL drop_one_cycle: got %b want 0", fire_dropped); else n_pass++;
    endtask

    task automatic test_edge_retire_hit();
        do_reset();
        turret_x = 10'd638; turret_y = 10'd100; turret_dx = 10'd2; turret_dy = '0;
        fire_req = 1; tick();
        n_checks++; if (slot_active[0] !== 1'b1 || slot_x[9:0] !== 10'd638)
            $display("FAIL edge_launch: got act=%b x=%0d want 1/638", slot_active[0], slot_x[9:0]); else n_pass++;
        fire_req = 0; tick();
        n_checks++; if (slot_active[0] !== 1'b0) $display("FAIL retire_x640: got %b want 0", slot_active[0]); else n_pass++;
        repeat (9) tick();
        for (int k = 0; k < 3; k++) shoot(300 + k, 300, 0, 0);
        turret_x = 10'd200; turret_y = 10'd200; turret_dx = '0; turret_dy = '0;
        fire_req = 1; slot_hit = 4'b0100; tick();
        n_checks++; if (slot_active !== 4'b1011 || fire_ack !== 1'b1 || slot_x[39:30] !== 10'd200)
            $display("FAIL hit_and_launch: got active=%b ack=%b x3=%0d want 1011/1/200", slot_active, fire_ack, slot_x[39:30]); else n_pass++;
        fire_req = 0; slot_hit = '0; repeat (10) tick();
        fire_req = 1; slot_hit = 4'b0100; tick();
        n_checks++; if (slot_active !== 4'b1111) $display("FAIL hit_on_free_ignored: got %b want 1111", slot_active); else n_pass++;
        fire_req = 0; slot_hit = '0;
        do_reset();
        turret_x = 10'd10; turret_y = 10'd0; turret_dx = '0; turret_dy = 10'h3FF;
        fire_req = 1; tick(); fire_req = 0; tick();
        n_checks++; if (slot_active[0] !== 1'b0) $display("FAIL underflow_retire: got %b want 0", slot_active[0]); else n_pass++;
    endtask

    task automatic test_lifetime_and_reset();
        int k = 0;
        do_reset();
        turret_x = 10'd10; turret_y = 10'd10; turret_dx = '0; turret_dy = '0;
        fire_req = 1; tick(); fire_req = 0;
        while (slot_active[0] === 1'b1 && k < 400) begin tick(); k++; end
        n_checks++; if (k != LT + 1) $display("FAIL lifetime: got %0d cycles want %0d", k, LT + 1); else n_pass++;
        do_reset();
        shoot(100, 100, 1, 0); shoot(200, 100, 0, 1);
        fire_req = 1; tick(); fire_req = 0; tick(); tick();
        n_checks++; if (cooldown_busy !== 1'b1 || slot_active !== 4'b0111)
            $display("FAIL pre_reset_state: got busy=%b active=%b want 1/0111", cooldown_busy, slot_active); else n_pass++;
        Reset = 0; tick();
        n_checks++; if (slot_active !== '0 || slot_x !== '0 || slot_y !== '0 || {fire_ack, fire_dropped, cooldown_busy} !== 3'b000)
            $display("FAIL mid_cd_reset: got active=%b x=%h y=%h flags=%b want all 0", slot_active, slot_x, slot_y,
                     {fire_ack, fire_dropped, cooldown_busy}); else n_pass++;
        Reset = 1; tick();
    endtask

    task automatic test_random();
        int d;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            Reset    = ($urandom_range(0, 299) != 0);
            fire_req = ($urandom_range(0, 2) == 0);
            turret_x = 10'($urandom_range(0, SW - 1));
            turret_y = 10'($urandom_range(0, SH - 1));
            d = int'($urandom_range(0, 16)) - 8; turret_dx = 10'(d);
            d = int'($urandom_range(0, 16)) - 8; turret_dy = 10'(d);
            for (int k = 0; k < NS; k++) slot_hit[k] = ($urandom_range(0, 15) == 0);
            tick();
            n_checks++; if (slot_active !== m_act_vec())
                $display("FAIL rnd_active c=%0d: got %b want %b", c, slot_active, m_act_vec()); else n_pass++;
            n_checks++; if ({fire_ack, fire_dropped} !== {m_ack, m_drop})
                $display("FAIL rnd_ack_drop c=%0d: got %b want %b", c, {fire_ack, fire_dropped}, {m_ack, m_drop}); else n_pass++;
            n_checks++; if (cooldown_busy !== ((m_edge - m_last) < CD))
                $display("FAIL rnd_busy c=%0d: got %b want %b", c, cooldown_busy, (m_edge - m_last) < CD); else n_pass++;
            n_checks++; if ((slot_x & act_mask()) !== m_pos(0) || (slot_y & act_mask()) !== m_pos(1))
                $display("FAIL rnd_pos c=%0d: got x=%h y=%h want x=%h y=%h", c, slot_x & act_mask(), slot_y & act_mask(),
                         m_pos(0), m_pos(1)); else n_pass++;
        end
        Reset = 1; slot_hit = '0; fire_req = 0;
    endtask

    initial begin
        test_reset();
        test_launch();
        test_hold_repeat();
        test_full_drop();
        test_edge_retire_hit();
        test_lifetime_and_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
